// File: rtl/banco_reg_param.sv
// Parametrised register bank: 2**ADDR_WIDTH x DATA_WIDTH, two read ports, one write port,
// optional hardwired-zero entry 0, write-to-read bypass and registered read outputs.
module banco_reg_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    parameter int READ_REG   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] sel,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] selA,
    input  logic [ADDR_WIDTH-1:0] selB,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    output logic [15:0]           wr_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [15:0]           count_q;
    logic                  wr_ok;
    logic [DATA_WIDTH-1:0] val_a;
    logic [DATA_WIDTH-1:0] val_b;

    // A write aimed at the hardwired-zero entry is dropped entirely: no store, no count, no bypass.
    assign wr_ok = RegWrite && !((ZERO_REG != 0) && (sel == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[sel] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (wr_ok && (count_q != '1)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign wr_count = count_q;

    always_comb begin
        val_a = regs[selA];
        if ((ZERO_REG != 0) && (selA == '0)) begin
            val_a = '0;
        end else if ((BYPASS != 0) && wr_ok && (selA == sel)) begin
            val_a = data;
        end
    end

    always_comb begin
        val_b = regs[selB];
        if ((ZERO_REG != 0) && (selB == '0)) begin
            val_b = '0;
        end else if ((BYPASS != 0) && wr_ok && (selB == sel)) begin
            val_b = data;
        end
    end

    generate
        if (READ_REG != 0) begin : g_read_reg
            logic [DATA_WIDTH-1:0] rd1_q;
            logic [DATA_WIDTH-1:0] rd2_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    rd1_q <= '0;
                    rd2_q <= '0;
                end else begin
                    rd1_q <= val_a;
                    rd2_q <= val_b;
                end
            end

            assign ReadData1 = rd1_q;
            assign ReadData2 = rd2_q;
        end else begin : g_read_comb
            assign ReadData1 = val_a;
            assign ReadData2 = val_b;
        end
    endgenerate

endmodule

// File: tb/tb_banco_reg_param.sv
// Scoreboard bench: stimulus pushes expected read/count values tagged with the cycle they are due,
// a negedge monitor pops and compares them against four differently-parameterised instances.
module tb_banco_reg_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  sel;
    logic [31:0] data;
    logic [4:0]  selA;
    logic [4:0]  selB;

    logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1, rd1_2, rd2_2;
    logic [15:0] wc_0, wc_1, wc_2, wc_3;

    logic        reset3;
    logic        RegWrite3;
    logic [2:0]  sel3;
    logic [15:0] data3;
    logic [2:0]  selA3;
    logic [2:0]  selB3;
    logic [15:0] rd1_3, rd2_3;

    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        int unsigned cyc;
        int          id;
        logic [31:0] val;
        string       name;
    } chk_t;

    chk_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // default: zero reg, bypass, combinational reads
    banco_reg_param u0 (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .sel(sel), .data(data),
        .selA(selA), .selB(selB), .ReadData1(rd1_0), .ReadData2(rd2_0), .wr_count(wc_0)
    );

    banco_reg_param #(.BYPASS(0)) u1 (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .sel(sel), .data(data),
        .selA(selA), .selB(selB), .ReadData1(rd1_1), .ReadData2(rd2_1), .wr_count(wc_1)
    );

    banco_reg_param #(.READ_REG(1)) u2 (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .sel(sel), .data(data),
        .selA(selA), .selB(selB), .ReadData1(rd1_2), .ReadData2(rd2_2), .wr_count(wc_2)
    );

    banco_reg_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(0)) u3 (
        .clk(clk), .reset(reset3), .RegWrite(RegWrite3), .sel(sel3), .data(data3),
        .selA(selA3), .selB(selB3), .ReadData1(rd1_3), .ReadData2(rd2_3), .wr_count(wc_3)
    );

    function automatic logic [31:0] actual(input int id);
        case (id)
            0:       return rd1_0;
            1:       return rd2_0;
            2:       return {16'h0, wc_0};
            3:       return rd1_1;
            4:       return rd2_1;
            5:       return {16'h0, wc_1};
            6:       return rd1_2;
            7:       return rd2_2;
            8:       return {16'h0, wc_2};
            9:       return {16'h0, rd1_3};
            10:      return {16'h0, rd2_3};
            default: return {16'h0, wc_3};
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input int id, input logic [31:0] v, input int unsigned lag, input string nm);
        chk_t c;
        c.cyc  = cyc + lag;
        c.id   = id;
        c.val  = v;
        c.name = nm;
        q.push_back(c);
    endtask

    // Monitor: every expectation due this cycle is compared against the live outputs.
    always @(negedge clk) begin
        int k;
        logic [31:0] a;
        k = 0;
        while (k < q.size()) begin
            if (q[k].cyc <= cyc) begin
                a = actual(q[k].id);
                checks = checks + 1;
                if (q[k].cyc != cyc || a !== q[k].val) begin
                    errors = errors + 1;
                    $display("FAIL %s: got %h expected %h (due cycle %0d, now %0d)",
                             q[k].name, a, q[k].val, q[k].cyc, cyc);
                end
                q.delete(k);
            end else begin
                k = k + 1;
            end
        end
    end

    task automatic shared_seq;
        reset = 1'b1; RegWrite = 1'b0; sel = '0; data = '0; selA = '0; selB = '0;
        tick();
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            selA = 5'(i);
            selB = 5'(31 - i);
            expect_v(0, 32'h0, 0, "sweep_u0_a");
            expect_v(1, 32'h0, 0, "sweep_u0_b");
            expect_v(3, 32'h0, 0, "sweep_u1_a");
            expect_v(4, 32'h0, 0, "sweep_u1_b");
            expect_v(6, 32'h0, 1, "sweep_u2_a");
            expect_v(7, 32'h0, 1, "sweep_u2_b");
            if (i == 0) begin
                expect_v(2, 32'h0, 0, "reset_wc_u0");
                expect_v(5, 32'h0, 0, "reset_wc_u1");
                expect_v(8, 32'h0, 0, "reset_wc_u2");
            end
            tick();
        end

        RegWrite = 1'b1; sel = 5'd5; data = 32'hDEADBEEF; selA = 5'd5; selB = 5'd0;
        expect_v(0, 32'hDEADBEEF, 0, "wr5_bypass_u0");
        expect_v(1, 32'h0,        0, "wr5_r0_u0");
        expect_v(3, 32'h0,        0, "wr5_nobypass_u1");
        expect_v(6, 32'hDEADBEEF, 1, "wr5_u2_lat");
        tick();

        RegWrite = 1'b0;
        expect_v(0, 32'hDEADBEEF, 0, "rd5_u0");
        expect_v(1, 32'h0,        0, "rd0_u0");
        expect_v(3, 32'hDEADBEEF, 0, "rd5_u1");
        expect_v(2, 32'h1,        0, "wc1_u0");
        tick();

        RegWrite = 1'b1; sel = 5'd0; data = 32'h12345678; selA = 5'd0; selB = 5'd5;
        expect_v(0, 32'h0,        0, "wr0_nobypass_u0");
        expect_v(1, 32'hDEADBEEF, 0, "wr0_rd5_u0");
        tick();

        RegWrite = 1'b0;
        expect_v(0, 32'h0, 0, "zero_reg_u0");
        expect_v(3, 32'h0, 0, "zero_reg_u1");
        expect_v(2, 32'h1, 0, "wc_after_zero_u0");
        expect_v(5, 32'h1, 0, "wc_after_zero_u1");
        expect_v(8, 32'h1, 0, "wc_after_zero_u2");
        tick();

        RegWrite = 1'b1; sel = 5'd7; data = 32'hA5A5A5A5; selA = 5'd7; selB = 5'd7;
        expect_v(0, 32'hA5A5A5A5, 0, "byp7_u0_a");
        expect_v(1, 32'hA5A5A5A5, 0, "byp7_u0_b");
        expect_v(3, 32'h0,        0, "nobyp7_u1_a");
        expect_v(4, 32'h0,        0, "nobyp7_u1_b");
        expect_v(6, 32'hA5A5A5A5, 1, "byp7_u2_lat");
        tick();

        RegWrite = 1'b0;
        expect_v(3, 32'hA5A5A5A5, 0, "rd7_u1_a");
        expect_v(4, 32'hA5A5A5A5, 0, "rd7_u1_b");
        expect_v(0, 32'hA5A5A5A5, 0, "rd7_u0_a");
        tick();

        RegWrite = 1'b1; sel = 5'd31; data = 32'h0000CAFE; selA = 5'd0; selB = 5'd0;
        tick();

        RegWrite = 1'b0; selA = 5'd31;
        expect_v(6, 32'h0,        0, "rr_not_early_u2");
        expect_v(6, 32'h0000CAFE, 1, "rr_one_edge_u2");
        expect_v(0, 32'h0000CAFE, 0, "rd31_u0");
        tick();

        reset = 1'b1; RegWrite = 1'b1; sel = 5'd3; data = 32'hFFFFFFFF; selA = 5'd3; selB = 5'd7;
        expect_v(0, 32'hFFFFFFFF, 0, "rst_cycle_bypass_u0");
        expect_v(4, 32'hA5A5A5A5, 0, "rst_cycle_old_u1");
        tick();

        reset = 1'b0; RegWrite = 1'b0;
        expect_v(0, 32'h0, 0, "rst_wr_lost_u0");
        expect_v(1, 32'h0, 0, "rst_clear7_u0");
        expect_v(3, 32'h0, 0, "rst_wr_lost_u1");
        expect_v(6, 32'h0, 0, "rst_outreg_u2");
        expect_v(2, 32'h0, 0, "rst_wc_u0");
        expect_v(5, 32'h0, 0, "rst_wc_u1");
        expect_v(8, 32'h0, 0, "rst_wc_u2");
        tick();

        RegWrite = 1'b1; sel = 5'd1; selA = 5'd2; selB = 5'd2;
        for (int n = 0; n < 70000; n++) begin
            data = 32'(n);
            if (n == 65534) expect_v(2, 32'h0000FFFE, 0, "wc_fffe_u0");
            if (n == 65535) begin
                expect_v(2, 32'h0000FFFF, 0, "wc_ffff_u0");
                expect_v(8, 32'h0000FFFF, 0, "wc_ffff_u2");
            end
            if (n == 65536) expect_v(2, 32'h0000FFFF, 0, "wc_hold_u0");
            tick();
        end

        RegWrite = 1'b0; selA = 5'd1; selB = 5'd0;
        expect_v(2, 32'h0000FFFF, 0, "wc_sat_u0");
        expect_v(5, 32'h0000FFFF, 0, "wc_sat_u1");
        expect_v(8, 32'h0000FFFF, 0, "wc_sat_u2");
        expect_v(0, 32'h0001116F, 0, "last_wr1_u0");
        expect_v(3, 32'h0001116F, 0, "last_wr1_u1");
        expect_v(6, 32'h0001116F, 1, "last_wr1_u2");
        tick();
        tick();
    endtask

    task automatic small_seq;
        logic [15:0] m3 [8];
        logic [15:0] exp_a, exp_b;
        int unsigned cnt;

        reset3 = 1'b1; RegWrite3 = 1'b0; sel3 = '0; data3 = '0; selA3 = '0; selB3 = '0;
        tick();
        reset3 = 1'b0;
        RegWrite3 = 1'b1; sel3 = 3'd0; data3 = 16'hBEEF; selA3 = 3'd0; selB3 = 3'd7;
        expect_v(9,  32'h0000BEEF, 0, "s_byp0");
        expect_v(10, 32'h0,        0, "s_rd7_reset");
        tick();
        sel3 = 3'd7; data3 = 16'h1234;
        expect_v(9,  32'h0000BEEF, 0, "s_entry0");
        expect_v(10, 32'h00001234, 0, "s_byp7");
        tick();
        RegWrite3 = 1'b0;
        expect_v(9,  32'h0000BEEF, 0, "s_entry0_hold");
        expect_v(10, 32'h00001234, 0, "s_entry7_hold");
        expect_v(11, 32'h2,        0, "s_wc2");
        tick();

        for (int i = 0; i < 8; i++) m3[i] = 16'h0;
        m3[0] = 16'hBEEF;
        m3[7] = 16'h1234;
        cnt = 2;
        for (int n = 0; n < 300; n++) begin
            RegWrite3 = 1'($urandom_range(0, 1));
            sel3      = 3'($urandom_range(0, 7));
            data3     = 16'($urandom);
            selA3     = 3'($urandom_range(0, 7));
            selB3     = 3'($urandom_range(0, 7));
            exp_a = (RegWrite3 && selA3 == sel3) ? data3 : m3[selA3];
            exp_b = (RegWrite3 && selB3 == sel3) ? data3 : m3[selB3];
            expect_v(9,  {16'h0, exp_a}, 0, "s_rand_a");
            expect_v(10, {16'h0, exp_b}, 0, "s_rand_b");
            expect_v(11, cnt, 0, "s_rand_wc");
            if (RegWrite3) begin
                m3[sel3] = data3;
                cnt = cnt + 1;
            end
            tick();
        end
        RegWrite3 = 1'b0;
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        fork
            shared_seq();
            small_seq();
        join
        tick();
        tick();
        if (q.size() != 0) begin
            $display("FAIL leftover: got %0d pending expectations, required 0", q.size());
            errors = errors + q.size();
            checks = checks + q.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
